// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_WIDTH       = 12;
    localparam int DATA_WIDTH       = 16;
    localparam int MEM_READ_LATENCY = 2;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } mem_src_t;

    typedef struct packed {
        logic     valid;
        mem_src_t src;
        logic     is_read;
    } resp_tag_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_prio
// Description : Data-priority grant logic with bounded fetch starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic ls_req,
    output logic if_gnt,
    output logic ls_gnt
);
    import mem_arb_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_force_if;

    assign w_force_if = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // Grants are suppressed during reset so nothing is accepted that would be flushed.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!reset) begin
            if (ls_req && !(if_req && w_force_if)) begin
                ls_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            r_starve_cnt <= '0;
        end else if (ls_gnt && !w_force_if) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between fetch and load/store.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    input  logic [DATA_WIDTH-1:0] MEM_MEMCTRL_from_mem_data,
    output logic                  MEMCTRL_MEM_to_mem_read_enable,
    output logic                  MEMCTRL_MEM_to_mem_write_enable,
    output logic                  MEMCTRL_MEM_to_mem_mem_enable,
    output logic [ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
    output logic [DATA_WIDTH-1:0] MEMCTRL_MEM_to_mem_data
);
    import mem_arb_pkg::*;

    logic                  w_if_gnt;
    logic                  w_ls_gnt;
    logic                  w_any_gnt;
    logic                  w_is_write;
    logic [ADDR_WIDTH-1:0] w_addr;
    resp_tag_t             w_tag_in;
    resp_tag_t             w_tag_out;
    logic                  w_if_rvalid;
    logic                  w_ls_rvalid;

    logic                  r_mem_en;
    logic                  r_rd_en;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    resp_tag_t             r_tag [MEM_READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_if_hold;
    logic [DATA_WIDTH-1:0] r_ls_hold;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clock  (clock),
        .reset  (reset),
        .if_req (if_req),
        .ls_req (ls_req),
        .if_gnt (w_if_gnt),
        .ls_gnt (w_ls_gnt)
    );

    assign if_gnt     = w_if_gnt;
    assign ls_gnt     = w_ls_gnt;
    assign w_any_gnt  = w_if_gnt | w_ls_gnt;
    assign w_is_write = w_ls_gnt & ls_we;
    assign w_addr     = w_ls_gnt ? ls_addr : if_addr;

    always_comb begin
        w_tag_in         = '0;
        w_tag_in.valid   = w_any_gnt;
        w_tag_in.src     = w_ls_gnt ? SRC_LS : SRC_IF;
        w_tag_in.is_read = ~w_is_write;
    end

    // Tag chain tracks each access until the memory's dout belongs to it.
    assign w_tag_out   = r_tag[MEM_READ_LATENCY-1];
    assign w_if_rvalid = w_tag_out.valid & w_tag_out.is_read & (w_tag_out.src == SRC_IF);
    assign w_ls_rvalid = w_tag_out.valid & w_tag_out.is_read & (w_tag_out.src == SRC_LS);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_en   <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_if_hold  <= '0;
            r_ls_hold  <= '0;
            for (int i = 0; i < MEM_READ_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_mem_en <= w_any_gnt;
            r_rd_en  <= w_any_gnt & ~w_is_write;
            r_wr_en  <= w_is_write;
            if (w_any_gnt) begin
                r_mem_addr <= w_addr;
            end
            if (w_is_write) begin
                r_mem_din <= ls_wdata;
            end
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < MEM_READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_if_rvalid) begin
                r_if_hold <= MEM_MEMCTRL_from_mem_data;
            end
            if (w_ls_rvalid) begin
                r_ls_hold <= MEM_MEMCTRL_from_mem_data;
            end
        end
    end

    assign if_rvalid = w_if_rvalid;
    assign ls_rvalid = w_ls_rvalid;
    assign if_rdata  = w_if_rvalid ? MEM_MEMCTRL_from_mem_data : r_if_hold;
    assign ls_rdata  = w_ls_rvalid ? MEM_MEMCTRL_from_mem_data : r_ls_hold;

    assign MEMCTRL_MEM_to_mem_mem_enable    = r_mem_en;
    assign MEMCTRL_MEM_to_mem_read_enable   = r_rd_en;
    assign MEMCTRL_MEM_to_mem_write_enable  = r_wr_en;
    assign MEMCTRL_MEM_to_mem_address       = r_mem_addr;
    assign MEMCTRL_MEM_to_mem_data          = r_mem_din;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 4096x16 program/data memory between two requesters:
  - the instruction-fetch unit (read-only);
  - the load/store unit (read/write).
- Sits between the CPU core and the memory controller pins (`MEMCTRL_MEM_to_mem_*` / `MEM_MEMCTRL_from_mem_data`).
- Accepts one access per cycle, drives the memory through registered outputs, and returns read data with a fixed latency.
- Arbitration is data-priority with a bounded fetch-starvation guarantee.

Parameters:
- ADDR_WIDTH, 12, word address width (4096 x 16-bit words).
- DATA_WIDTH, 16, memory word width.
- STARVE_LIMIT, 4, max consecutive data grants while fetch is pending before fetch is forced.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  if_rdata valid (registered).
- if_rdata  out  DATA_WIDTH  fetch read data.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  ADDR_WIDTH  load/store word address.
- ls_wdata  in  DATA_WIDTH  store data.
- ls_gnt  out  1  load/store request accepted this cycle (combinational).
- ls_rvalid  out  1  ls_rdata valid (registered; reads only).
- ls_rdata  out  DATA_WIDTH  load read data.
- MEM_MEMCTRL_from_mem_data  in  16  memory dout.
- MEMCTRL_MEM_to_mem_read_enable  out  1  memory rd_en.
- MEMCTRL_MEM_to_mem_write_enable  out  1  memory wr_en.
- MEMCTRL_MEM_to_mem_mem_enable  out  1  memory en.
- MEMCTRL_MEM_to_mem_address  out  12  memory address.
- MEMCTRL_MEM_to_mem_data  out  16  memory din.

Behaviour:

Reset (synchronous, dominant):
- All memory outputs are 0; if_rvalid = ls_rvalid = 0; rdata outputs are 0.
- Starvation counter is 0; response pipeline is flushed.
- gnt outputs are 0 while reset = 1.

Arbitration, evaluated each cycle:
- ls_req only: ls_gnt.
- if_req only: if_gnt.
- Both: ls_gnt, unless starve_cnt == STARVE_LIMIT, in which case if_gnt.
- At most one gnt per cycle.

Starvation counter:
- Increments on each ls_gnt while if_req = 1.
- Clears on if_gnt, or when if_req = 0.
- Saturates at STARVE_LIMIT.

Pipeline, for a grant in cycle N:
- Stage 1 (edge ending N): register the memory outputs.
  - en = 1, address = granted address.
  - Read grant: rd_en = 1, wr_en = 0.
  - Write grant: wr_en = 1, rd_en = 0, din = ls_wdata.
  - Also register the response tag: {valid, src = IF/LS, is_read}.
- Stage 2 (edge ending N+1): memory samples the registered outputs; dout is valid during N+2.
  - The tag is delayed one more stage.
  - In N+2, the matching rvalid = 1 and rdata = MEM_MEMCTRL_from_mem_data (combinational pass-through gated by rvalid).
  - Non-matching rdata holds its last value.
- Read latency: gnt in N, rvalid in N+2.
- Throughput: one access per cycle, back-to-back, with mixed sources allowed.
- Writes produce no rvalid.

Idle handling:
- A cycle with no grant registers en = rd_en = wr_en = 0.
- Address and din hold their previous values.

Boundary conditions:
- Address 0xFFF is legal; there is no wrap or increment inside the block.
- Requester drops req without gnt: nothing is issued.
- Reset asserted with accesses in flight: in-flight responses are discarded, no rvalid after reset, no write reaches memory if reset coincides with its stage-1 edge.
- Simultaneous rd_en and wr_en never occur.

Decomposition:
- Package mem_arb_pkg:
  - typedef mem_src_t enum {SRC_IF, SRC_LS};
  - struct resp_tag_t {valid, src, is_read};
  - constants ADDR_WIDTH = 12, DATA_WIDTH = 16, MEM_READ_LATENCY = 2.
- One sub-module, mem_arb_prio: combinational grant logic plus the starvation counter register.
- Pipeline registers live in the top.

Test Plan:
1. if_req = 1, if_addr = 0x010, memory word 0x010 = 0xBEEF:
   - if_gnt in cycle N;
   - en = 1, rd_en = 1, address = 0x010 in N+1;
   - if_rvalid = 1, if_rdata = 0xBEEF in N+2.
2. Same cycle: if_req addr 0x020 and ls_req read addr 0x100:
   - ls_gnt first, ls_rvalid at N+2;
   - if_gnt at N+1, if_rvalid at N+3 with word 0x020.
3. ls_req write, addr 0x005, data 0x1234, then ls_req read 0x005 the next cycle:
   - wr_en pulse with din = 0x1234;
   - no rvalid for the write;
   - read returns 0x1234 two cycles after its gnt.
4. ls_req held high for 10 cycles with if_req held high:
   - ls_gnt in cycles 0–3;
   - if_gnt in cycle 4;
   - ls_gnt resumes in cycle 5.
5. Grants issued in cycles N and N+1, then reset = 1 at N+1:
   - no rvalid in N+2/N+3;
   - all memory enables 0 from the first edge with reset high.
6. Alternating IF/LS reads to addresses 0x000 and 0xFFF every cycle for 20 cycles:
   - one rvalid per cycle, correct source routing, correct data.
